// File: rtl/rule110_sequencer.sv
// ---------------------------------------------------------------------------
// rule110_sequencer
// Host-side sequencer for an attached Rule 110 cell array built from 8-cell
// blocks. The sequencer does three things: it loads the array one byte per
// block, advances it a given number of generations, and reads it back one
// byte per block.
//
// Ports
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready       command handshake (ready only when idle)
//   i_cmd_op[1:0], i_cmd_arg[15:0]  00 LOAD, 01 RUN (arg = generations),
//                                   10 DUMP, 11 reserved (accepted, no-op)
//   i_wr_valid/o_wr_ready/i_wr_data load byte stream, one block per byte
//   o_rd_valid/i_rd_ready/o_rd_data dump byte stream, one block per byte
//   o_core_we_n, o_core_halt_n      array write enable / run (both active low
//                                   sense: we_n=0 writes, halt_n=0 freezes)
//   o_core_addr, o_core_wdata       block address and write data to array
//   i_core_rdata                    next-generation block data from array
//   o_busy                          high whenever not idle
//   o_gen_count                     generations run since last full LOAD
//
// States
//   S_IDLE | waiting for a command, array frozen
//   S_LOAD | accepting bytes into blocks 0..NUM_BLOCKS-1
//   S_RUN  | array free-running, one generation per cycle
//   S_DUMP | presenting blocks 0..NUM_BLOCKS-1, array frozen
// ---------------------------------------------------------------------------
module rule110_sequencer #(
    parameter int NUM_BLOCKS = 29,
    parameter int ADDR_BITS  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [1:0]           i_cmd_op,
    input  logic [15:0]          i_cmd_arg,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [7:0]           i_wr_data,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [7:0]           o_rd_data,
    output logic                 o_core_we_n,
    output logic                 o_core_halt_n,
    output logic [ADDR_BITS-1:0] o_core_addr,
    output logic [7:0]           o_core_wdata,
    input  logic [7:0]           i_core_rdata,
    output logic                 o_busy,
    output logic [15:0]          o_gen_count
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;

    localparam logic [ADDR_BITS-1:0] LAST_BLK = ADDR_BITS'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_BITS-1:0] r_blk;
    logic [15:0]          r_steps;
    logic [15:0]          r_gen;

    logic w_cmd_fire;
    logic w_wr_fire;
    logic w_rd_fire;
    logic w_last_blk;

    assign w_cmd_fire = i_cmd_valid && (r_state == S_IDLE);
    assign w_wr_fire  = i_wr_valid  && (r_state == S_LOAD);
    assign w_rd_fire  = i_rd_ready  && (r_state == S_DUMP);
    assign w_last_blk = (r_blk == LAST_BLK);

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    case (i_cmd_op)
                        OP_LOAD: w_next_state = S_LOAD;
                        OP_DUMP: w_next_state = S_DUMP;
                        // RUN 0 and the reserved op are consumed without leaving idle
                        OP_RUN:  w_next_state = (i_cmd_arg != 16'd0) ? S_RUN : S_IDLE;
                        default: w_next_state = S_IDLE;
                    endcase
                end
            end
            S_LOAD:  if (w_wr_fire && w_last_blk) w_next_state = S_IDLE;
            // r_steps is never 0 in RUN; <= keeps a corrupted count from running away
            S_RUN:   if (r_steps <= 16'd1)        w_next_state = S_IDLE;
            S_DUMP:  if (w_rd_fire && w_last_blk) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Block pointer, remaining-step counter, generation counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_blk   <= '0;
            r_steps <= 16'd0;
            r_gen   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_blk <= '0;
                        if (i_cmd_op == OP_RUN) r_steps <= i_cmd_arg;
                    end
                end
                S_LOAD: begin
                    if (w_wr_fire) begin
                        r_blk <= w_last_blk ? '0 : r_blk + 1'b1;
                        if (w_last_blk) r_gen <= 16'd0;
                    end
                end
                S_RUN: begin
                    r_steps <= r_steps - 16'd1;
                    if (r_gen != 16'hFFFF) r_gen <= r_gen + 16'd1;
                end
                S_DUMP: begin
                    if (w_rd_fire) r_blk <= w_last_blk ? '0 : r_blk + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs; the array is only ever written in LOAD and only runs in RUN,
    // so write and run can never be active together.
    always_comb begin
        o_cmd_ready   = 1'b0;
        o_wr_ready    = 1'b0;
        o_rd_valid    = 1'b0;
        o_rd_data     = 8'h00;
        o_core_we_n   = 1'b1;
        o_core_halt_n = 1'b0;
        o_core_addr   = '0;
        o_core_wdata  = 8'h00;
        case (r_state)
            S_IDLE: o_cmd_ready = 1'b1;
            S_LOAD: begin
                o_wr_ready   = 1'b1;
                o_core_we_n  = !i_wr_valid;
                o_core_addr  = r_blk;
                o_core_wdata = i_wr_data;
            end
            S_RUN:  o_core_halt_n = 1'b1;
            S_DUMP: begin
                o_rd_valid  = 1'b1;
                o_rd_data   = i_core_rdata;
                o_core_addr = r_blk;
            end
            default: ;
        endcase
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_gen_count = r_gen;

endmodule

// File: tb/tb_rule110_sequencer.sv
module tb_rule110_sequencer;

    localparam int NB = 4;
    localparam int AB = 6;
    localparam int CW = 8 * NB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [15:0]   cmd_arg = 16'd0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [7:0]    wr_data = 8'h00;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [7:0]    rd_data;
    logic          core_we_n;
    logic          core_halt_n;
    logic [AB-1:0] core_addr;
    logic [7:0]    core_wdata;
    logic [7:0]    core_rdata;
    logic          busy;
    logic [15:0]   gen_count;

    int checks = 0;
    int errors = 0;

    rule110_sequencer #(.NUM_BLOCKS(NB), .ADDR_BITS(AB)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_arg(cmd_arg),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
        .o_core_we_n(core_we_n), .o_core_halt_n(core_halt_n),
        .o_core_addr(core_addr), .o_core_wdata(core_wdata),
        .i_core_rdata(core_rdata),
        .o_busy(busy), .o_gen_count(gen_count)
    );

    always #5 clk = ~clk;

    // Rule 110 on a ring of CW cells: new cell = bit {left,self,right} of 110.
    function automatic logic [CW-1:0] rule_step(input logic [CW-1:0] c);
        logic [CW-1:0] n;
        int idx;
        for (int i = 0; i < CW; i++) begin
            idx = {29'd0, c[(i + 1) % CW], c[i], c[(i + CW - 1) % CW]};
            n[i] = ((110 >> idx) & 1) != 0;
        end
        return n;
    endfunction

    function automatic logic [CW-1:0] evolve(input logic [CW-1:0] c, input int n);
        logic [CW-1:0] v = c;
        for (int i = 0; i < n; i++) v = rule_step(v);
        return v;
    endfunction

    // Attached cell array: write on we_n, advance on halt_n, output gen T+1.
    logic [CW-1:0] arr = '0;
    logic [CW-1:0] arr_next;
    always @(posedge clk) begin
        if (!core_we_n) begin
            if (int'(core_addr) < NB) arr[int'(core_addr)*8 +: 8] <= core_wdata;
        end else if (core_halt_n) begin
            arr <= rule_step(arr);
        end
    end
    always_comb begin
        arr_next   = rule_step(arr);
        core_rdata = 8'h00;
        if (int'(core_addr) < NB) core_rdata = arr_next[int'(core_addr)*8 +: 8];
    end

    // Reference model state
    logic [CW-1:0] m_cells = '0;
    int            m_steps = 0;
    int            m_gen = 0;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        #1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [CW-1:0] bytes);
        issue(2'b00, 16'd0);
        for (int k = 0; k < NB; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr_valid = 1'b0;
                #1;
                check("load_idle_we_n", 32'(core_we_n), 32'd1);
                check("load_wr_ready", 32'(wr_ready), 32'd1);
                @(negedge clk);
            end
            wr_valid = 1'b1;
            wr_data  = bytes[k*8 +: 8];
            #1;
            check("load_we_n", 32'(core_we_n), 32'd0);
            check("load_addr", 32'(core_addr), 32'(k));
            check("load_wdata", 32'(core_wdata), 32'(bytes[k*8 +: 8]));
            check("load_halt_n", 32'(core_halt_n), 32'd0);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("load_done_busy", 32'(busy), 32'd0);
        check("load_gen_clear", 32'(gen_count), 32'd0);
        m_cells = bytes;
        m_steps = 0;
        m_gen   = 0;
    endtask

    task automatic do_run(input int n, input bit poke);
        int hc = 0;
        int cyc = 0;
        issue(2'b01, 16'(n));
        while (busy && cyc < n + 10) begin
            check("run_gen", 32'(gen_count), 32'(sat16(m_gen + hc)));
            check("run_we_n", 32'(core_we_n), 32'd1);
            if (poke) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'b00;
                #1;
            end
            check("run_cmd_ready", 32'(cmd_ready), 32'd0);
            if (core_halt_n) hc++;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check("run_timeout", 32'(cyc < n + 10), 32'd1);
        check("run_halt_cycles", 32'(hc), 32'(n));
        check("run_end_halt_n", 32'(core_halt_n), 32'd0);
        check("run_end_gen", 32'(gen_count), 32'(sat16(m_gen + n)));
        check("run_not_loading", 32'(wr_ready), 32'd0);
        m_gen   = sat16(m_gen + n);
        m_steps = m_steps + n;
    endtask

    task automatic do_dump();
        logic [CW-1:0] e;
        logic [7:0]    prev = 8'h00;
        bit            stalled = 1'b0;
        int            k = 0;
        int            p = 0;
        int            cyc = 0;
        e = evolve(m_cells, m_steps + 1);
        issue(2'b10, 16'h1234);
        while (busy && cyc < 200) begin
            check("dump_rd_valid", 32'(rd_valid), 32'd1);
            check("dump_halt_n", 32'(core_halt_n), 32'd0);
            check("dump_addr", 32'(core_addr), 32'(k));
            if (k < NB) check("dump_data", 32'(rd_data), 32'(e[k*8 +: 8]));
            if (stalled) check("dump_stable", 32'(rd_data), 32'(prev));
            rd_ready = (p % 3 == 0);
            prev     = rd_data;
            stalled  = !rd_ready;
            if (rd_ready) k++;
            p++;
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b0;
        check("dump_timeout", 32'(cyc < 200), 32'd1);
        check("dump_count", 32'(k), 32'(NB));
        check("dump_gen_same", 32'(gen_count), 32'(m_gen));
    endtask

    initial begin
        logic [CW-1:0] rb;
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halt_n", 32'(core_halt_n), 32'd0);
        check("rst_we_n", 32'(core_we_n), 32'd1);
        check("rst_addr", 32'(core_addr), 32'd0);
        check("rst_wdata", 32'(core_wdata), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed: load 01,02,04,80, run 5, dump
        do_load({8'h80, 8'h04, 8'h02, 8'h01});
        do_run(5, 1'b0);
        do_dump();

        // Randomized load/run/dump rounds
        for (int r = 0; r < 4; r++) begin
            rb = $urandom;
            do_load(rb);
            do_run($urandom_range(1, 20), 1'b1);
            do_dump();
        end

        // RUN 0 and reserved op: accepted, no activity
        issue(2'b01, 16'd0);
        check("run0_busy", 32'(busy), 32'd0);
        check("run0_halt_n", 32'(core_halt_n), 32'd0);
        check("run0_gen", 32'(gen_count), 32'(m_gen));
        issue(2'b11, 16'($urandom));
        check("op11_busy", 32'(busy), 32'd0);
        check("op11_halt_n", 32'(core_halt_n), 32'd0);
        check("op11_gen", 32'(gen_count), 32'(m_gen));

        // Reset mid-RUN after 3 of 10 steps
        rb = $urandom;
        do_load(rb);
        issue(2'b01, 16'd10);
        for (int i = 0; i < 3; i++) begin
            check("mid_halt_n", 32'(core_halt_n), 32'd1);
            check("mid_gen", 32'(gen_count), 32'(i));
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_halt_n", 32'(core_halt_n), 32'd0);
        check("arst_gen", 32'(gen_count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        m_steps = 3;
        m_gen   = 0;
        do_dump();

        // Saturation: FFFE then 4 more with commands offered during RUN
        rb = $urandom;
        do_load(rb);
        do_run(65534, 1'b0);
        check("sat_fffe", 32'(gen_count), 32'h0000FFFE);
        do_run(4, 1'b1);
        check("sat_ffff", 32'(gen_count), 32'h0000FFFF);
        @(negedge clk);
        check("sat_hold", 32'(gen_count), 32'h0000FFFF);
        check("sat_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rule110_sequencer.md
RULE110_SEQUENCER -- requirements
Module: rule110_sequencer

Interface
REQ-001 Parameter NUM_BLOCKS, default 29, number of 8-cell blocks in the attached cell array; legal range 1..63.
REQ-002 Parameter ADDR_BITS, default 6, width of core block address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  host command offered.
REQ-006 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-007 cmd_op  input  2  00 LOAD, 01 RUN, 10 DUMP, 11 reserved.
REQ-008 cmd_arg  input  16  generation count for RUN; ignored otherwise.
REQ-009 wr_valid / wr_ready / wr_data  input / output / input  1/1/8  load-byte stream, one block per byte.
REQ-010 rd_valid / rd_ready / rd_data  output / input / output  1/1/8  dump-byte stream, one block per byte.
REQ-011 core_we_n  output  1  to cell array write-enable (active low).
REQ-012 core_halt_n  output  1  to cell array halt (low = frozen).
REQ-013 core_addr  output  ADDR_BITS  cell block address.
REQ-014 core_wdata  output  8  cell data to array.
REQ-015 core_rdata  input  8  next-generation block data from array.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 gen_count  output  16  generations advanced since last completed LOAD.

Function
REQ-018 FSM states IDLE, LOAD, RUN, DUMP; cmd_ready = 1 only in IDLE.
REQ-019 IDLE: core_halt_n=0, core_we_n=1, core_addr=0, wr_ready=0, rd_valid=0.
REQ-020 Command handshake (cmd_valid & cmd_ready) in IDLE: LOAD->LOAD, DUMP->DUMP, RUN with cmd_arg>0 ->RUN, RUN with cmd_arg=0 or op 11 -> accepted, stay IDLE, no core activity.
REQ-021 Block counter blk resets to 0 on every LOAD/DUMP entry; core_addr = blk in LOAD and DUMP.
REQ-022 LOAD: wr_ready=1; core_we_n = !wr_valid (combinational); core_wdata = wr_data; each wr handshake writes block blk and increments blk.
REQ-023 LOAD: handshake with blk = NUM_BLOCKS-1 -> IDLE next cycle and gen_count cleared to 0.
REQ-024 RUN: remaining-step counter loaded with cmd_arg at acceptance; core_halt_n=1 for exactly cmd_arg consecutive cycles, then IDLE with core_halt_n=0.
REQ-025 RUN: gen_count increments once per cycle core_halt_n=1; saturates at 16'hFFFF.
REQ-026 DUMP: rd_valid=1, rd_data = core_rdata (combinational), core_halt_n=0 so data holds stable under backpressure.
REQ-027 DUMP: rd handshake increments blk; handshake at blk = NUM_BLOCKS-1 -> IDLE next cycle.
REQ-028 DUMP reports generation T+1 of the array (array output semantics); gen_count unchanged by DUMP.
REQ-029 core_we_n=0 only in LOAD; core_halt_n=1 only in RUN; never both active.
REQ-030 cmd_valid while busy: ignored (not accepted, not queued).
REQ-031 core_addr never equals all-ones (guaranteed by NUM_BLOCKS <= 63).

Reset
REQ-032 reset asserted: state=IDLE, blk=0, step counter=0, gen_count=0, core_we_n=1, core_halt_n=0, core_addr=0, core_wdata=0, cmd_ready=1 on release, busy=0, wr_ready=0, rd_valid=0.
REQ-033 reset mid-LOAD/RUN/DUMP aborts immediately; partial writes into array are not undone.

Verification
REQ-034 LOAD with NUM_BLOCKS=4, bytes 01,02,04,80 -> core_we_n low in 4 handshake cycles, core_addr 0,1,2,3, core_wdata matches, IDLE after 4th, gen_count=0.
REQ-035 RUN cmd_arg=5 -> core_halt_n high exactly 5 cycles, gen_count 0->5, busy low the cycle after the 5th.
REQ-036 DUMP with rd_ready toggling 1,0,0,1,... -> rd_data stable while stalled, core_addr advances only on handshake, exactly NUM_BLOCKS bytes delivered.
REQ-037 RUN cmd_arg=0 and op 11 -> accepted, busy stays 0, core_halt_n stays 0, gen_count unchanged.
REQ-038 reset asserted mid-RUN after 3 of 10 steps -> core_halt_n=0 asynchronously, gen_count=0, cmd_ready=1 after release.
REQ-039 gen_count at 16'hFFFE, RUN cmd_arg=4 -> gen_count 16'hFFFF, holds; cmd_valid during RUN not accepted.
